// File: rtl/program_counter.sv
// Program counter for the single-cycle RV32I core.
// Holds the fetch address and picks the next PC from sequential, branch,
// JAL or JALR targets. A stall holds the PC. A misaligned redirect target
// sends the PC to the trap vector and raises a flag for the control unit.
module program_counter #(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = 32'h00000000,
    parameter logic [XLEN-1:0]      TRAP_VECTOR  = 32'h00000100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jal,
    input  logic [XLEN-1:0] jal_target,
    input  logic            jalr,
    input  logic [XLEN-1:0] jalr_base,
    input  logic [XLEN-1:0] jalr_offset,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned
);

    // JALR clears bit 0 of its sum, so only bit 1 can make it misaligned.
    localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] redirect_target;
    logic            redirect_active;

    assign pc_out   = pc_reg;
    assign pc_plus4 = pc_reg + XLEN'(4);
    assign jalr_sum = jalr_base + jalr_offset;

    // Pick the winning redirect (jalr > jal > branch) and flag misalignment;
    // a stalled cycle never redirects and never reports misalignment.
    always_comb begin
        redirect_active = ~stall & (jalr | jal | branch_taken);
        redirect_target = branch_target;
        misaligned      = 1'b0;
        if (jalr) begin
            redirect_target = jalr_sum & JALR_MASK;
        end else if (jal) begin
            redirect_target = jal_target;
        end
        if (redirect_active) begin
            if (jalr) begin
                misaligned = redirect_target[1];
            end else begin
                misaligned = |redirect_target[1:0];
            end
        end
    end

    // Next-PC selection: hold on stall, trap on a bad target, else redirect or step by 4.
    always_comb begin
        pc_next = pc_plus4;
        if (stall) begin
            pc_next = pc_reg;
        end else if (misaligned) begin
            pc_next = TRAP_VECTOR;
        end else if (redirect_active) begin
            pc_next = redirect_target;
        end
    end

    // PC register; reset loads the reset vector immediately and wins over everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg <= RESET_VECTOR;
        end else begin
            pc_reg <= pc_next;
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios followed by
// randomized control traffic, compared against an arithmetic reference model.
module tb_program_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jal;
    logic [31:0] jal_target;
    logic        jalr;
    logic [31:0] jalr_base;
    logic [31:0] jalr_offset;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        misaligned;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_pc;

    program_counter dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jal           (jal),
        .jal_target    (jal_target),
        .jalr          (jalr),
        .jalr_base     (jalr_base),
        .jalr_offset   (jalr_offset),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: target chosen by priority, alignment judged by remainder mod 4.
    function automatic logic [31:0] ref_target();
        logic [31:0] s;
        if (jalr) begin
            s = jalr_base + jalr_offset;
            return s - (s % 2);
        end
        if (jal) return jal_target;
        return branch_target;
    endfunction

    function automatic logic ref_misaligned();
        if (stall || !(jalr || jal || branch_taken)) return 1'b0;
        return (ref_target() % 4) != 0;
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] pc);
        if (stall) return pc;
        if (ref_misaligned()) return 32'h00000100;
        if (jalr || jal || branch_taken) return ref_target();
        return pc + 32'd4;
    endfunction

    task automatic idle_inputs();
        stall = 0; branch_taken = 0; jal = 0; jalr = 0;
        branch_target = 0; jal_target = 0; jalr_base = 0; jalr_offset = 0;
    endtask

    // One clock: check the combinational flag, clock, then check the new PC.
    task automatic step(input string tag);
        logic [31:0] exp_pc;
        #1;
        check({tag, ".mis"}, {31'd0, misaligned}, {31'd0, ref_misaligned()});
        exp_pc = ref_next(model_pc);
        @(posedge clk);
        #1;
        model_pc = exp_pc;
        check({tag, ".pc"}, pc_out, model_pc);
        check({tag, ".pc4"}, pc_plus4, model_pc + 32'd4);
        $display("step %-10s pc_out=%h pc_plus4=%h", tag, pc_out, pc_plus4);
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_pc = 32'h0;
        #1;
        check("reset.pc", pc_out, 32'h0);
        check("reset.pc4", pc_plus4, 32'h4);
        #9 reset = 1'b0;

        // Sequential fetch: 4, 8
        step("seq1");
        step("seq2");
        check("seq_at8", pc_out, 32'h8);
        // Branch to 0x40 then 0x44
        branch_taken = 1; branch_target = 32'h40;
        step("branch");
        check("br_40", pc_out, 32'h40);
        step("seq44");
        // JALR clears bit 0
        jalr = 1; jalr_base = 32'h1001; jalr_offset = 32'hFFFFFFFF;
        step("jalr");
        check("jalr_1000", pc_out, 32'h1000);
        // JAL beats branch
        jal = 1; jal_target = 32'h200; branch_taken = 1; branch_target = 32'h300;
        step("jal_pri");
        check("jal_200", pc_out, 32'h200);
        // Get to C, stall 3 cycles with a pending branch, then release
        jal = 1; jal_target = 32'hC;
        step("to_c");
        for (int i = 0; i < 3; i++) begin
            stall = 1; branch_taken = 1; branch_target = 32'h80;
            step("stall");
        end
        check("stall_c", pc_out, 32'hC);
        step("release");
        check("rel_10", pc_out, 32'h10);
        // Misaligned branch traps
        branch_taken = 1; branch_target = 32'h42;
        #1 check("mis42", {31'd0, misaligned}, 32'd1);
        step("mis_br");
        check("trap_100", pc_out, 32'h100);
        // JALR: bit1 set traps, bit0 only does not
        jalr = 1; jalr_base = 32'h2; jalr_offset = 32'h0; jal = 1; jal_target = 32'h400;
        step("jalr_b1");
        jalr = 1; jalr_base = 32'h5; jalr_offset = 32'h0;
        step("jalr_b0");
        // Stall masks a misaligned target
        stall = 1; jal = 1; jal_target = 32'h3;
        step("stall_mis");
        // Wrap-around
        jal = 1; jal_target = 32'hFFFFFFFC;
        step("to_top");
        step("wrap");
        check("wrap_0", pc_out, 32'h0);

        // Mid-run reset with active redirects and stall
        step("pre_rst");
        #3;
        stall = 1; jal = 1; jal_target = 32'h500;
        reset = 1'b1;
        #1 check("async_rst", pc_out, 32'h0);
        @(posedge clk);
        #1 check("rst_hold", pc_out, 32'h0);
        #3 reset = 1'b0;
        idle_inputs();
        model_pc = 32'h0;
        step("post_rst");
        check("post_rst_4", pc_out, 32'h4);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            stall         = ($urandom_range(0, 7) == 0);
            jalr          = ($urandom_range(0, 5) == 0);
            jal           = ($urandom_range(0, 5) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_target = $urandom;
            jal_target    = $urandom;
            jalr_base     = $urandom;
            jalr_offset   = $urandom;
            if ($urandom_range(0, 3) != 0) branch_target[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) jal_target[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) jalr_base[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) jalr_offset[1:0] = 2'($urandom_range(0, 1));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
